signext_unit: RTL and testbench

- Registered immediate sign-extender for the LEGv8 single-cycle/pipelined datapath.
- Takes a 32-bit instruction word, recognises the immediate-bearing formats, and produces the 64-bit sign-extended immediate one clock later.
- Sits between the instruction fetch register and the ALU/branch-offset mux.
- Unrecognised instructions yield zero.

---
 rtl/signext_pkg.sv | 29 ++
 rtl/signext_decode.sv | 54 +++++
 rtl/signext_unit.sv | 55 +++++
 tb/tb_signext_unit.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/signext_pkg.sv
// Shared widths, LEGv8 opcode constants and immediate-format enum for the sign-extender.
// Optional branch formats (CBNZ, B) are enabled by SIGNEXT_BRANCH_EN.
package signext_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned OUT_WIDTH  = 64;

  localparam int unsigned OPC_D_W  = 11;
  localparam int unsigned OPC_CB_W = 8;
  localparam int unsigned OPC_B_W  = 6;

  localparam int unsigned IMM_D_W  = 9;
  localparam int unsigned IMM_CB_W = 19;
  localparam int unsigned IMM_B_W  = 26;

  localparam logic [OPC_D_W-1:0]  OP_LDUR = 11'b11111000010;
  localparam logic [OPC_D_W-1:0]  OP_STUR = 11'b11111000000;
  localparam logic [OPC_CB_W-1:0] OP_CBZ  = 8'b10110100;
  localparam logic [OPC_CB_W-1:0] OP_CBNZ = 8'b10110101;
  localparam logic [OPC_B_W-1:0]  OP_B    = 6'b000101;

  typedef enum logic [1:0] {
    FMT_NONE = 2'd0,
    FMT_D    = 2'd1,
    FMT_CB   = 2'd2,
    FMT_B    = 2'd3
  } imm_fmt_t;

endpackage : signext_pkg

// File: rtl/signext_decode.sv
// Combinational LEGv8 immediate decode: instruction word -> format and sign-extended value.
// CBNZ and B are only recognised when SIGNEXT_BRANCH_EN is defined.
module signext_decode
  import signext_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] a,
  output imm_fmt_t              fmt_c,
  output logic [OUT_WIDTH-1:0]  imm_c
);

  logic [OPC_D_W-1:0]  opc_d;
  logic [OPC_CB_W-1:0] opc_cb;
  logic [IMM_D_W-1:0]  imm_d;
  logic [IMM_CB_W-1:0] imm_cb;
  logic                unused_c;

  assign opc_d    = a[31:21];
  assign opc_cb   = a[31:24];
  assign imm_d    = a[20:12];
  assign imm_cb   = a[23:5];
  // Register-number field Rt never feeds an immediate.
  assign unused_c = ^a[4:0];

`ifdef SIGNEXT_BRANCH_EN
  logic [OPC_B_W-1:0] opc_b;
  logic [IMM_B_W-1:0] imm_b;

  assign opc_b = a[31:26];
  assign imm_b = a[25:0];
`endif

  // 11-bit D-type opcodes take priority over the 8-bit CB-type opcodes.
  always_comb begin
    fmt_c = FMT_NONE;
    imm_c = '0;
    if (opc_d == OP_LDUR || opc_d == OP_STUR) begin
      fmt_c = FMT_D;
      imm_c = {{(OUT_WIDTH-IMM_D_W){imm_d[IMM_D_W-1]}}, imm_d};
    end else if (opc_cb == OP_CBZ) begin
      fmt_c = FMT_CB;
      imm_c = {{(OUT_WIDTH-IMM_CB_W){imm_cb[IMM_CB_W-1]}}, imm_cb};
    end
`ifdef SIGNEXT_BRANCH_EN
    else if (opc_cb == OP_CBNZ) begin
      fmt_c = FMT_CB;
      imm_c = {{(OUT_WIDTH-IMM_CB_W){imm_cb[IMM_CB_W-1]}}, imm_cb};
    end else if (opc_b == OP_B) begin
      fmt_c = FMT_B;
      imm_c = {{(OUT_WIDTH-IMM_B_W){imm_b[IMM_B_W-1]}}, imm_b};
    end
`endif
  end

endmodule : signext_decode

// File: rtl/signext_unit.sv
// Registered LEGv8 immediate sign-extender: one-cycle latency, no backpressure.
// Define SIGNEXT_BRANCH_EN to additionally support CBNZ and B.
module signext_unit
  import signext_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] a,
  output logic                  out_valid,
  output logic [OUT_WIDTH-1:0]  y,
  output logic                  known
);

  imm_fmt_t             fmt_c;
  logic [OUT_WIDTH-1:0] imm_c;

  logic                 valid_d, valid_q;
  logic [OUT_WIDTH-1:0] y_d, y_q;
  logic                 known_d, known_q;

  signext_decode u_decode (
    .a     (a),
    .fmt_c (fmt_c),
    .imm_c (imm_c)
  );

  // y/known only update on a valid word; otherwise they hold.
  always_comb begin
    valid_d = in_valid;
    y_d     = y_q;
    known_d = known_q;
    if (in_valid) begin
      y_d     = imm_c;
      known_d = (fmt_c != FMT_NONE);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      y_q     <= '0;
      known_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      y_q     <= y_d;
      known_q <= known_d;
    end
  end

  assign out_valid = valid_q;
  assign y         = y_q;
  assign known     = known_q;

endmodule : signext_unit

// File: tb/tb_signext_unit.sv
// Self-checking bench for signext_unit: directed vectors plus randomized words
// checked against an arithmetic reference model of the immediate formats.
module tb_signext_unit;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [31:0] a;
  logic        out_valid;
  logic [63:0] y;
  logic        known;

  int n_checks = 0;
  int n_fail   = 0;

  logic        exp_valid;
  logic [63:0] exp_y;
  logic        exp_known;

  signext_unit dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .a         (a),
    .out_valid (out_valid),
    .y         (y),
    .known     (known)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: extract the field as an unsigned number, then wrap into two's complement range.
  function automatic void ref_decode(input logic [31:0] w, output logic [63:0] imm, output logic k);
    longint v;
    v   = 0;
    k   = 1'b1;
    if (w[31:21] == 11'b11111000010 || w[31:21] == 11'b11111000000) begin
      v = longint'(w[20:12]);
      if (v >= 256) v = v - 512;
    end else if (w[31:24] == 8'b10110100) begin
      v = longint'(w[23:5]);
      if (v >= (1 << 18)) v = v - (1 << 19);
    end
`ifdef SIGNEXT_BRANCH_EN
    else if (w[31:24] == 8'b10110101) begin
      v = longint'(w[23:5]);
      if (v >= (1 << 18)) v = v - (1 << 19);
    end else if (w[31:26] == 6'b000101) begin
      v = longint'(w[25:0]);
      if (v >= (1 << 25)) v = v - (1 << 26);
    end
`endif
    else begin
      k = 1'b0;
    end
    imm = 64'(v);
  endfunction

  task automatic check_outputs(input string tag);
    check_eq({tag, ".valid"}, 64'(out_valid), 64'(exp_valid));
    check_eq({tag, ".y"},     y,              exp_y);
    check_eq({tag, ".known"}, 64'(known),     64'(exp_known));
  endtask

  // Present one word at the falling edge, then check just after the next rising edge.
  task automatic apply(input string tag, input logic v, input logic [31:0] w);
    logic [63:0] m_y;
    logic        m_k;
    @(negedge clk);
    in_valid = v;
    a        = w;
    @(posedge clk);
    #1;
    exp_valid = v;
    if (v) begin
      ref_decode(w, m_y, m_k);
      exp_y     = m_y;
      exp_known = m_k;
    end
    check_outputs(tag);
  endtask

  task automatic apply_lit(input string tag, input logic [31:0] w, input logic [63:0] ey, input logic ek);
    apply(tag, 1'b1, w);
    check_eq({tag, ".lit_y"},     y,          ey);
    check_eq({tag, ".lit_known"}, 64'(known), 64'(ek));
  endtask

  initial begin
    logic [31:0] w;
    logic        v;
    logic [63:0] held_y;

    reset     = 1'b0;
    in_valid  = 1'b1;
    a         = 32'hF8403422;
    exp_valid = 1'b0;
    exp_y     = '0;
    exp_known = 1'b0;

    // Clock keeps running with a valid LDUR while reset is held.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_outputs("reset_hold");
    end
    @(negedge clk);
    reset    = 1'b1;
    in_valid = 1'b0;

    apply_lit("ldur_pos", 32'hF8403422, 64'h3, 1'b1);

    // Asynchronous reset between edges clears outputs at once.
    #2;
    reset = 1'b0;
    #1;
    exp_valid = 1'b0;
    exp_y     = '0;
    exp_known = 1'b0;
    check_outputs("async_rst");
    @(negedge clk);
    reset = 1'b1;

    apply_lit("ldur_neg", {11'b11111000010, 9'b100000000, 12'h0}, 64'hFFFF_FFFF_FFFF_FF00, 1'b1);
    apply_lit("stur_pos", {11'b11111000000, 9'd3, 12'h0},         64'h3,                 1'b1);
    apply_lit("stur_neg", {11'b11111000000, 9'b100000011, 12'h0}, 64'hFFFF_FFFF_FFFF_FF03, 1'b1);
    apply_lit("cbz_pos",  32'hB4000021, 64'h1,                   1'b1);
    apply_lit("cbz_neg",  32'hB4800021, 64'hFFFF_FFFF_FFFC_0001, 1'b1);
    apply_lit("add",      {11'b10001011000, 21'h0A5A5}, 64'h0, 1'b0);
    apply_lit("and",      32'h8A000000, 64'h0, 1'b0);
`ifdef SIGNEXT_BRANCH_EN
    apply_lit("cbnz",     32'hB5800021, 64'hFFFF_FFFF_FFFC_0001, 1'b1);
    apply_lit("b_neg1",   {6'b000101, 26'h3FFFFFF}, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
`else
    apply_lit("cbnz",     32'hB5800021, 64'h0, 1'b0);
    apply_lit("b_neg1",   {6'b000101, 26'h3FFFFFF}, 64'h0, 1'b0);
`endif

    // Back-to-back stream, then a one-cycle gap where y must hold.
    apply_lit("stream_ldur", 32'hF8403422, 64'h3, 1'b1);
    apply_lit("stream_cbz",  32'hB4800021, 64'hFFFF_FFFF_FFFC_0001, 1'b1);
    apply_lit("stream_ldur2", {11'b11111000010, 9'b111111111, 12'h0}, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    held_y = y;
    apply("gap", 1'b0, 32'h8B000000);
    check_eq("gap.hold_y", y, held_y);
    apply_lit("stream_add",  {11'b10001011000, 21'h0}, 64'h0, 1'b0);

    // Randomized words biased toward each recognised format.
    for (int i = 0; i < 400; i++) begin
      w = $urandom;
      case ($urandom_range(0, 5))
        0: w[31:21] = 11'b11111000010;
        1: w[31:21] = 11'b11111000000;
        2: w[31:24] = 8'b10110100;
        3: w[31:24] = 8'b10110101;
        4: w[31:26] = 6'b000101;
        default: ;
      endcase
      v = ($urandom_range(0, 4) != 0);
      apply("rand", v, w);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_signext_unit
